// File: rtl/dmx_pkg.sv
// Shared types and constants for the DMX512 transmit path.
package dmx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_MAB,
        ST_SLOT
    } dmx_state_t;

    localparam int unsigned DMX_SLOT_BITS = 11;
    localparam int unsigned DMX_MAX_SLOTS = 512;
    localparam int unsigned DMX_CLK_DIV   = 48;

    function automatic int unsigned dmx_max3(input int unsigned a, input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dmx_bit_timer.sv
// Restartable CLK_DIV divider; bit_tick marks the last clock of every bit time.
module dmx_bit_timer
    import dmx_pkg::*;
#(
    parameter int unsigned CLK_DIV = DMX_CLK_DIV
) (
    input  logic clk_In,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);

    localparam int unsigned   TW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLK_DIV - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk_In) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

    assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/dmx_tx_framer.sv
// DMX512 packet framer: BREAK, MAB, start code, then SLOT_COUNT buffered slots.
module dmx_tx_framer
    import dmx_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DMX_CLK_DIV,
    parameter int unsigned BREAK_BITS = 25,
    parameter int unsigned MAB_BITS   = 3,
    parameter int unsigned SLOT_COUNT = DMX_MAX_SLOTS
) (
    input  logic       clk_In,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] start_code,
    output logic       rd_en,
    output logic [8:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PH_MAX = dmx_max3(BREAK_BITS, MAB_BITS, DMX_SLOT_BITS);
    localparam int unsigned PH_W   = $clog2(PH_MAX);

    localparam logic [PH_W-1:0] BREAK_LAST = PH_W'(BREAK_BITS - 1);
    localparam logic [PH_W-1:0] MAB_LAST   = PH_W'(MAB_BITS - 1);
    localparam logic [PH_W-1:0] BIT_STOP1  = PH_W'(9);
    localparam logic [PH_W-1:0] BIT_LAST   = PH_W'(DMX_SLOT_BITS - 1);
    localparam logic [9:0]      SLOT_LAST  = 10'(SLOT_COUNT);

    dmx_state_t      state, state_nxt;
    logic [PH_W-1:0] phase, phase_nxt, phase_inc;
    logic [9:0]      slot, slot_nxt;
    logic [7:0]      shift_reg, shift_nxt;
    logic [7:0]      next_byte, next_byte_nxt;
    logic            rd_pend;
    logic            tx_nxt, busy_nxt, done_nxt, rd_en_nxt;
    logic [8:0]      rd_addr_nxt;
    logic            bit_tick;

    // Holding the divider in reset while idle aligns the first BREAK bit to acceptance.
    dmx_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk_In   (clk_In),
        .rst      (rst),
        .restart  (state == ST_IDLE),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk_In) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase     <= '0;
            slot      <= '0;
            shift_reg <= '0;
            next_byte <= '0;
            rd_pend   <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            slot      <= slot_nxt;
            shift_reg <= shift_nxt;
            next_byte <= next_byte_nxt;
            rd_pend   <= rd_en;
            tx        <= tx_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            rd_en     <= rd_en_nxt;
            rd_addr   <= rd_addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        phase_inc     = phase + PH_W'(1);
        slot_nxt      = slot;
        shift_nxt     = shift_reg;
        next_byte_nxt = rd_pend ? rd_data : next_byte;
        tx_nxt        = tx;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        rd_en_nxt     = 1'b0;
        rd_addr_nxt   = rd_addr;

        unique case (state)
            ST_IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                // The done cycle is already IDLE, but a start there must not be taken.
                if (start && !done) begin
                    state_nxt = ST_BREAK;
                    phase_nxt = '0;
                    slot_nxt  = '0;
                    shift_nxt = start_code;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            ST_BREAK: begin
                if (bit_tick) begin
                    if (phase == BREAK_LAST) begin
                        state_nxt   = ST_MAB;
                        phase_nxt   = '0;
                        tx_nxt      = 1'b1;
                        rd_en_nxt   = 1'b1;
                        rd_addr_nxt = '0;
                    end else begin
                        phase_nxt = phase_inc;
                    end
                end
            end
            ST_MAB: begin
                if (bit_tick) begin
                    if (phase == MAB_LAST) begin
                        state_nxt = ST_SLOT;
                        phase_nxt = '0;
                        tx_nxt    = 1'b0;
                    end else begin
                        phase_nxt = phase_inc;
                    end
                end
            end
            ST_SLOT: begin
                if (bit_tick) begin
                    if (phase == BIT_LAST) begin
                        phase_nxt = '0;
                        if (slot == SLOT_LAST) begin
                            state_nxt = ST_IDLE;
                            slot_nxt  = '0;
                            tx_nxt    = 1'b1;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end else begin
                            slot_nxt  = slot + 10'd1;
                            shift_nxt = next_byte;
                            tx_nxt    = 1'b0;
                        end
                    end else begin
                        phase_nxt = phase_inc;
                        if (phase_inc < BIT_STOP1) begin
                            tx_nxt    = shift_reg[0];
                            shift_nxt = {1'b0, shift_reg[7:1]};
                        end else begin
                            tx_nxt = 1'b1;
                            // Slot k (1..SLOT_COUNT-1) fetches the byte for slot k+1; slot 1's came in MAB.
                            if (phase_inc == BIT_STOP1 && slot != 10'd0 && slot != SLOT_LAST) begin
                                rd_en_nxt   = 1'b1;
                                rd_addr_nxt = slot[8:0];
                            end
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmx_tx_framer.sv
// Self-checking bench for dmx_tx_framer against a bit-timeline model of the DMX packet.
module tb_dmx_tx_framer;

    localparam int BRK     = 25;
    localparam int MAB     = 3;
    localparam int A_DIV   = 4;
    localparam int A_SLOTS = 3;
    localparam int A_FRAME = (BRK + MAB + 11 * (A_SLOTS + 1)) * A_DIV;
    localparam int B_DIV   = 2;
    localparam int B_SLOTS = 512;
    localparam int B_FRAME = (BRK + MAB + 11 * (B_SLOTS + 1)) * B_DIV;

    logic       clk;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] sc_a, sc_b;
    logic       rd_en_a, rd_en_b;
    logic [8:0] rd_addr_a, rd_addr_b;
    logic [7:0] rd_data_a, rd_data_b;
    logic       tx_a, tx_b, busy_a, busy_b, done_a, done_b;

    logic [7:0] mem_a [512];
    logic [7:0] mem_b [512];

    int checks;
    int errors;

    dmx_tx_framer #(
        .CLK_DIV    (A_DIV),
        .BREAK_BITS (BRK),
        .MAB_BITS   (MAB),
        .SLOT_COUNT (A_SLOTS)
    ) dut_a (
        .clk_In     (clk),
        .rst        (rst),
        .start      (start_a),
        .start_code (sc_a),
        .rd_en      (rd_en_a),
        .rd_addr    (rd_addr_a),
        .rd_data    (rd_data_a),
        .tx         (tx_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    dmx_tx_framer #(
        .CLK_DIV    (B_DIV),
        .BREAK_BITS (BRK),
        .MAB_BITS   (MAB),
        .SLOT_COUNT (B_SLOTS)
    ) dut_b (
        .clk_In     (clk),
        .rst        (rst),
        .start      (start_b),
        .start_code (sc_b),
        .rd_en      (rd_en_b),
        .rd_addr    (rd_addr_b),
        .rd_data    (rd_data_b),
        .tx         (tx_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel buffers with a fixed one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
        if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level i cycles after acceptance.
    function automatic logic exp_tx(input int i, input int d, input int slots,
                                    input logic [7:0] sc, input bit use_b);
        int bit_no, slot_no, b;
        logic [7:0] byt;
        if (i < BRK * d) return 1'b0;
        if (i < (BRK + MAB) * d) return 1'b1;
        bit_no  = (i - (BRK + MAB) * d) / d;
        slot_no = bit_no / 11;
        b       = bit_no % 11;
        if (slot_no > slots) return 1'b1;
        if (slot_no == 0) byt = sc;
        else byt = use_b ? mem_b[slot_no - 1] : mem_a[slot_no - 1];
        if (b == 0) return 1'b0;
        if (b <= 8) return byt[b - 1];
        return 1'b1;
    endfunction

    // Cycle offset (after acceptance) of the k-th buffer read.
    function automatic int exp_rd_off(input int k, input int d);
        if (k == 0) return BRK * d;
        return (BRK + MAB) * d + (11 * k + 9) * d;
    endfunction

    task automatic run_frame_a(input logic [7:0] sc, input bit accepted, input bit mid_start,
                               input bit chain, input logic [7:0] next_sc, input string tag);
        int   tx_bad, busy_bad, first_bad;
        int   rd_off[$];
        int   rd_adr[$];
        logic txs [A_FRAME];
        logic [7:0] dec, want;
        bit   framing_ok;
        int   base, half;
        if (!accepted) begin
            sc_a    = sc;
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            sc_a    = 8'($urandom);
        end
        tx_bad = 0; busy_bad = 0; first_bad = -1;
        for (int i = 0; i <= A_FRAME; i++) begin
            if (i > 0) tick();
            if (i < A_FRAME) begin
                txs[i] = tx_a;
                if (tx_a !== exp_tx(i, A_DIV, A_SLOTS, sc, 1'b0)) begin
                    tx_bad++;
                    if (first_bad < 0) first_bad = i;
                end
                if (busy_a !== 1'b1 || done_a !== 1'b0) busy_bad++;
                if (rd_en_a === 1'b1) begin
                    rd_off.push_back(i);
                    rd_adr.push_back(int'(rd_addr_a));
                end
            end else begin
                checks++;
                if (done_a !== 1'b1 || busy_a !== 1'b0 || tx_a !== 1'b1) begin
                    errors++;
                    $display("FAIL %s end_of_frame done=%b busy=%b tx=%b required done=1 busy=0 tx=1 at cycle %0d",
                             tag, done_a, busy_a, tx_a, i);
                end
            end
            if (mid_start && i == 150) begin
                start_a = 1'b1;
                sc_a    = ~sc;
            end else if (mid_start && i == 151) begin
                start_a = 1'b0;
            end
        end
        checks++;
        if (tx_bad !== 0) begin
            errors++;
            $display("FAIL %s tx_waveform bad_cycles=%0d first_at=%0d required 0", tag, tx_bad, first_bad);
        end
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL %s busy_done_in_frame bad_cycles=%0d required 0", tag, busy_bad);
        end
        checks++;
        if (rd_off.size() !== A_SLOTS) begin
            errors++;
            $display("FAIL %s rd_count got %0d required %0d", tag, rd_off.size(), A_SLOTS);
        end else begin
            for (int k = 0; k < A_SLOTS; k++) begin
                checks++;
                if (rd_off[k] !== exp_rd_off(k, A_DIV) || rd_adr[k] !== k) begin
                    errors++;
                    $display("FAIL %s rd_%0d got cycle %0d addr %0d required cycle %0d addr %0d",
                             tag, k, rd_off[k], rd_adr[k], exp_rd_off(k, A_DIV), k);
                end
            end
        end
        half = A_DIV / 2;
        for (int s = 0; s <= A_SLOTS; s++) begin
            base = (BRK + MAB) * A_DIV + s * 11 * A_DIV;
            framing_ok = (txs[base + half] == 1'b0) && (txs[base + 9 * A_DIV + half] == 1'b1)
                         && (txs[base + 10 * A_DIV + half] == 1'b1);
            for (int b = 0; b < 8; b++) dec[b] = txs[base + (1 + b) * A_DIV + half];
            want = (s == 0) ? sc : mem_a[s - 1];
            checks++;
            if (dec !== want || !framing_ok) begin
                errors++;
                $display("FAIL %s slot_%0d decoded %h framing_ok=%0d required %h framing_ok=1",
                         tag, s, dec, framing_ok, want);
            end
        end
        if (chain) begin
            sc_a    = next_sc;
            start_a = 1'b1;
            tick();
            checks++;
            if (busy_a !== 1'b0 || tx_a !== 1'b1) begin
                errors++;
                $display("FAIL %s start_in_done_cycle busy=%b tx=%b required busy=0 tx=1", tag, busy_a, tx_a);
            end
            tick();
            start_a = 1'b0;
            checks++;
            if (busy_a !== 1'b1 || tx_a !== 1'b0) begin
                errors++;
                $display("FAIL %s start_after_done busy=%b tx=%b required busy=1 tx=0", tag, busy_a, tx_a);
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        tick();
        checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || rd_en_a !== 1'b0 || rd_addr_a !== 9'd0) begin
            errors++;
            $display("FAIL reset_values tx=%b busy=%b done=%b rd_en=%b rd_addr=%0d required 1 0 0 0 0",
                     tx_a, busy_a, done_a, rd_en_a, rd_addr_a);
        end
        repeat (2) tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || rd_en_a !== 1'b0 || done_a !== 1'b0
                || tx_b !== 1'b1 || busy_b !== 1'b0 || rd_en_b !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_hold bad_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_reference_frame();
        mem_a[0] = 8'hA5;
        mem_a[1] = 8'h01;
        mem_a[2] = 8'hFF;
        run_frame_a(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "reference");
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] sc1, sc2;
        sc1 = 8'($urandom);
        sc2 = 8'($urandom);
        for (int i = 0; i < A_SLOTS; i++) mem_a[i] = 8'($urandom);
        run_frame_a(sc1, 1'b0, 1'b1, 1'b1, sc2, "b2b_first");
        for (int i = 0; i < A_SLOTS; i++) mem_a[i] = 8'($urandom);
        run_frame_a(sc2, 1'b1, 1'b0, 1'b0, 8'h00, "b2b_second");
        tick();
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < A_SLOTS; i++) mem_a[i] = 8'($urandom);
            repeat (1 + $urandom_range(0, 5)) tick();
            run_frame_a(8'($urandom), 1'b0, 1'b0, 1'b0, 8'h00, "random");
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < A_SLOTS; i++) mem_a[i] = 8'($urandom);
        sc_a    = 8'($urandom);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        // Slot 2, bit 5 begins at (BRK+MAB+22+5)*DIV cycles after acceptance.
        for (int i = 0; i < (BRK + MAB + 27) * A_DIV; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || rd_en_a !== 1'b0 || rd_addr_a !== 9'd0) begin
            errors++;
            $display("FAIL mid_frame_reset tx=%b busy=%b done=%b rd_en=%b rd_addr=%0d required 1 0 0 0 0",
                     tx_a, busy_a, done_a, rd_en_a, rd_addr_a);
        end
        tick();
        for (int i = 0; i < A_SLOTS; i++) mem_a[i] = 8'($urandom);
        run_frame_a(8'($urandom), 1'b0, 1'b0, 1'b0, 8'h00, "after_reset");
        tick();
    endtask

    task automatic test_long_frame();
        logic [7:0] sc;
        int tx_bad, first_bad, done_at, n_rd, rd_bad;
        for (int i = 0; i < B_SLOTS; i++) mem_b[i] = 8'($urandom);
        sc      = 8'($urandom);
        sc_b    = sc;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tx_bad = 0; first_bad = -1; done_at = -1; n_rd = 0; rd_bad = 0;
        for (int i = 0; i < B_FRAME + 20 && done_at < 0; i++) begin
            if (i > 0) tick();
            if (done_b === 1'b1) begin
                done_at = i;
            end else if (tx_b !== exp_tx(i, B_DIV, B_SLOTS, sc, 1'b1)) begin
                tx_bad++;
                if (first_bad < 0) first_bad = i;
            end
            if (rd_en_b === 1'b1) begin
                if (int'(rd_addr_b) !== n_rd || i !== exp_rd_off(n_rd, B_DIV)) rd_bad++;
                n_rd++;
            end
        end
        checks++;
        if (done_at !== B_FRAME) begin
            errors++;
            $display("FAIL long_frame_length done_at=%0d required %0d", done_at, B_FRAME);
        end
        checks++;
        if (tx_bad !== 0) begin
            errors++;
            $display("FAIL long_frame_tx bad_cycles=%0d first_at=%0d required 0", tx_bad, first_bad);
        end
        checks++;
        if (n_rd !== B_SLOTS || rd_bad !== 0) begin
            errors++;
            $display("FAIL long_frame_reads count=%0d out_of_order=%0d required count=%0d out_of_order=0",
                     n_rd, rd_bad, B_SLOTS);
        end
        tick();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        sc_a    = 8'h00;
        sc_b    = 8'h00;
        for (int i = 0; i < 512; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        test_reset();
        test_reference_frame();
        test_back_to_back();
        test_random_frames();
        test_reset_mid_frame();
        test_long_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
